// File: rtl/dccm_port_arbiter.sv
// Shares the single-port, 1-cycle-latency DCCM between the LSU (fixed priority) and a
// DMA/debug master, with a starvation counter and a read tag that steers returned data.
module dccm_port_arbiter #(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] lsu_dccm_raddr,
   input  logic            lsu_dccm_rvalid_in,
   input  logic [XLEN-1:0] lsu_dccm_waddr,
   input  logic            lsu_dccm_wen,
   input  logic [XLEN-1:0] lsu_dccm_wdata,
   output logic            lsu_dccm_stall,
   output logic [XLEN-1:0] lsu_dccm_rdata,
   output logic            lsu_dccm_rvalid_out,
   input  logic            dma_req,
   input  logic            dma_we,
   input  logic [XLEN-1:0] dma_addr,
   input  logic [XLEN-1:0] dma_wdata,
   output logic            dma_gnt,
   output logic [XLEN-1:0] dma_rdata,
   output logic            dma_rvalid,
   output logic            dccm_en,
   output logic            dccm_we,
   output logic [XLEN-1:0] dccm_addr,
   output logic [XLEN-1:0] dccm_wdata,
   input  logic [XLEN-1:0] dccm_rdata
);

   localparam int            CW         = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_LSU  = 2'd1,
      TAG_DMA  = 2'd2
   } rd_tag_e;

   typedef enum logic [1:0] {
      SEL_NONE   = 2'd0,
      SEL_LSU_WR = 2'd1,
      SEL_LSU_RD = 2'd2,
      SEL_DMA    = 2'd3
   } sel_e;

   sel_e          sel_s;
   logic          lsu_req_s;
   rd_tag_e       rd_tag_q, rd_tag_d;
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;

   assign lsu_req_s = lsu_dccm_wen | lsu_dccm_rvalid_in;

   // Winner selection; nothing is granted while reset is asserted
   always_comb begin
      sel_s = SEL_NONE;
      if (!rst_n) begin
         sel_s = SEL_NONE;
      end else if (dma_req && (starve_cnt_q == STARVE_LIM)) begin
         sel_s = SEL_DMA;
      end else if (lsu_dccm_wen) begin
         sel_s = SEL_LSU_WR;
      end else if (lsu_dccm_rvalid_in) begin
         sel_s = SEL_LSU_RD;
      end else if (dma_req) begin
         sel_s = SEL_DMA;
      end else begin
         sel_s = SEL_NONE;
      end
   end

   // Memory strobe, handshakes and the tag of the read issued this cycle
   always_comb begin
      dccm_en        = 1'b0;
      dccm_we        = 1'b0;
      dccm_addr      = '0;
      dccm_wdata     = '0;
      dma_gnt        = 1'b0;
      lsu_dccm_stall = 1'b0;
      rd_tag_d       = TAG_NONE;
      case (sel_s)
         SEL_LSU_WR: begin
            dccm_en        = 1'b1;
            dccm_we        = 1'b1;
            dccm_addr      = lsu_dccm_waddr;
            dccm_wdata     = lsu_dccm_wdata;
            // a read presented alongside the write waits one cycle
            lsu_dccm_stall = lsu_dccm_rvalid_in;
         end
         SEL_LSU_RD: begin
            dccm_en   = 1'b1;
            dccm_addr = lsu_dccm_raddr;
            rd_tag_d  = TAG_LSU;
         end
         SEL_DMA: begin
            dccm_en        = 1'b1;
            dccm_we        = dma_we;
            dccm_addr      = dma_addr;
            dma_gnt        = 1'b1;
            lsu_dccm_stall = lsu_req_s;
            if (dma_we) begin
               dccm_wdata = dma_wdata;
               rd_tag_d   = TAG_NONE;
            end else begin
               dccm_wdata = '0;
               rd_tag_d   = TAG_DMA;
            end
         end
         default: begin
            dccm_en = 1'b0;
         end
      endcase
   end

   // Starvation counter next state
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!dma_req || dma_gnt) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q == STARVE_LIM) begin
         starve_cnt_d = starve_cnt_q;
      end else begin
         starve_cnt_d = starve_cnt_q + CW'(1);
      end
   end

   // Tag and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_tag_q     <= TAG_NONE;
         starve_cnt_q <= '0;
      end else begin
         rd_tag_q     <= rd_tag_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign lsu_dccm_rvalid_out = (rd_tag_q == TAG_LSU);
   assign dma_rvalid          = (rd_tag_q == TAG_DMA);
   assign lsu_dccm_rdata      = lsu_dccm_rvalid_out ? dccm_rdata : '0;
   assign dma_rdata           = dma_rvalid ? dccm_rdata : '0;

endmodule

// File: tb/tb_dccm_port_arbiter.sv
// Scoreboard bench for dccm_port_arbiter with a behavioural 1-cycle DCCM whose
// initial contents are 0xA5A5_0000 | address[15:0].
module tb_dccm_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lsu_dccm_raddr, lsu_dccm_waddr, lsu_dccm_wdata;
   logic        lsu_dccm_rvalid_in, lsu_dccm_wen;
   logic        lsu_dccm_stall, lsu_dccm_rvalid_out;
   logic [31:0] lsu_dccm_rdata;
   logic        dma_req, dma_we, dma_gnt, dma_rvalid;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        dccm_en, dccm_we;
   logic [31:0] dccm_addr, dccm_wdata, dccm_rdata;

   int checks   = 0;
   int failures = 0;
   logic [31:0] lsu_q[$];
   logic [31:0] dma_q[$];

   logic [31:0] mem [0:16383];
   logic [31:0] mem_rdata;
   logic        mem_init;

   always #5 clk = ~clk;

   dccm_port_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_dccm_raddr(lsu_dccm_raddr), .lsu_dccm_rvalid_in(lsu_dccm_rvalid_in),
      .lsu_dccm_waddr(lsu_dccm_waddr), .lsu_dccm_wen(lsu_dccm_wen),
      .lsu_dccm_wdata(lsu_dccm_wdata), .lsu_dccm_stall(lsu_dccm_stall),
      .lsu_dccm_rdata(lsu_dccm_rdata), .lsu_dccm_rvalid_out(lsu_dccm_rvalid_out),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .dccm_en(dccm_en), .dccm_we(dccm_we), .dccm_addr(dccm_addr),
      .dccm_wdata(dccm_wdata), .dccm_rdata(dccm_rdata)
   );

   // Behavioural DCCM: registered read, write on enable
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16384; i++) mem[i] <= 32'hA5A5_0000 | {16'h0000, i[13:0], 2'b00};
      end else if (dccm_en) begin
         if (dccm_we) mem[dccm_addr[15:2]] <= dccm_wdata;
         else         mem_rdata <= mem[dccm_addr[15:2]];
      end
   end
   assign dccm_rdata = mem_rdata;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every returned read must match the oldest expectation of its owner
   always @(negedge clk) begin
      if (rst_n) begin
         if (lsu_dccm_rvalid_out) begin
            chk1("single_owner", dma_rvalid, 1'b0);
            chk32("dma_rdata_quiet", dma_rdata, 32'h0);
            if (lsu_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL lsu_unexpected_rvalid actual=%h expected=none", lsu_dccm_rdata);
            end else begin
               chk32("lsu_rdata", lsu_dccm_rdata, lsu_q.pop_front());
            end
         end
         if (dma_rvalid) begin
            chk32("lsu_rdata_quiet", lsu_dccm_rdata, 32'h0);
            if (dma_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL dma_unexpected_rvalid actual=%h expected=none", dma_rdata);
            end else begin
               chk32("dma_rdata", dma_rdata, dma_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input logic rd, input logic [31:0] ra, input logic wen,
                        input logic [31:0] wa, input logic [31:0] wd, input logic dq,
                        input logic dwe, input logic [31:0] da, input logic [31:0] dd);
      lsu_dccm_rvalid_in = rd;  lsu_dccm_raddr = ra;
      lsu_dccm_wen       = wen; lsu_dccm_waddr = wa; lsu_dccm_wdata = wd;
      dma_req = dq; dma_we = dwe; dma_addr = da; dma_wdata = dd;
   endtask

   // One clock of stimulus followed by checks of the combinational grant outputs
   task automatic cyc(input string nm, input logic rd, input logic [31:0] ra, input logic wen,
                      input logic [31:0] wa, input logic [31:0] wd, input logic dq,
                      input logic dwe, input logic [31:0] da, input logic [31:0] dd,
                      input logic e_stall, input logic e_gnt, input logic e_en,
                      input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wd);
      @(posedge clk); #1;
      drive(rd, ra, wen, wa, wd, dq, dwe, da, dd);
      @(negedge clk);
      chk1({nm, ".stall"}, lsu_dccm_stall, e_stall);
      chk1({nm, ".gnt"}, dma_gnt, e_gnt);
      chk1({nm, ".en"}, dccm_en, e_en);
      chk1({nm, ".we"}, dccm_we, e_we);
      chk32({nm, ".addr"}, dccm_addr, e_addr);
      chk32({nm, ".wdata"}, dccm_wdata, e_wd);
   endtask

   task automatic idle(input string nm);
      cyc(nm, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
          1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk1({nm, ".stall"}, lsu_dccm_stall, 1'b0);
      chk1({nm, ".lsu_rvalid"}, lsu_dccm_rvalid_out, 1'b0);
      chk32({nm, ".lsu_rdata"}, lsu_dccm_rdata, 32'h0);
      chk1({nm, ".gnt"}, dma_gnt, 1'b0);
      chk1({nm, ".dma_rvalid"}, dma_rvalid, 1'b0);
      chk32({nm, ".dma_rdata"}, dma_rdata, 32'h0);
      chk1({nm, ".en"}, dccm_en, 1'b0);
      chk1({nm, ".we"}, dccm_we, 1'b0);
      chk32({nm, ".addr"}, dccm_addr, 32'h0);
      chk32({nm, ".wdata"}, dccm_wdata, 32'h0);
   endtask

   initial begin
      rst_n    = 1'b0;
      mem_init = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      mem_init = 1'b0;
      rst_n    = 1'b1;

      // LSU read alone
      lsu_q.push_back(32'hA5A5_0FF0);
      cyc("t1_rd", 1'b1, 32'h0FF0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
          1'b0, 1'b0, 1'b1, 1'b0, 32'h0FF0, 32'h0);
      idle("t1_idle");

      // Write and read of the same address together: write first, read next cycle
      cyc("t2_wr", 1'b1, 32'h2000, 1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0,
          1'b1, 1'b0, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF);
      lsu_q.push_back(32'hDEAD_BEEF);
      cyc("t2_rd", 1'b1, 32'h2000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
          1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0);
      idle("t2_idle");

      // DMA read with the LSU idle
      dma_q.push_back(32'hA5A5_3000);
      cyc("t3_dma", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0,
          1'b0, 1'b1, 1'b1, 1'b0, 32'h3000, 32'h0);
      idle("t3_idle");

      // LSU reads every cycle while DMA waits: DMA forced in the 5th cycle
      for (int i = 0; i < 4; i++) begin
         lsu_q.push_back(32'hA5A5_0100);
         cyc("t4_lsu", 1'b1, 32'h0100, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0104, 32'h0,
             1'b0, 1'b0, 1'b1, 1'b0, 32'h0100, 32'h0);
      end
      dma_q.push_back(32'hA5A5_0104);
      cyc("t4_force", 1'b1, 32'h0100, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0104, 32'h0,
          1'b1, 1'b1, 1'b1, 1'b0, 32'h0104, 32'h0);
      // counter cleared by the grant, so a new DMA request loses to the LSU again
      lsu_q.push_back(32'hA5A5_0100);
      cyc("t4_after", 1'b1, 32'h0100, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0108, 32'h0,
          1'b0, 1'b0, 1'b1, 1'b0, 32'h0100, 32'h0);
      idle("t4_idle");

      // Alternating LSU / DMA reads back-to-back
      for (int i = 0; i < 3; i++) begin
         lsu_q.push_back(32'hA5A5_0000 | (32'h0200 + 32'(8 * i)));
         cyc("t5_lsu", 1'b1, 32'h0200 + 32'(8 * i), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             1'b0, 1'b0, 1'b1, 1'b0, 32'h0200 + 32'(8 * i), 32'h0);
         dma_q.push_back(32'hA5A5_0000 | (32'h0204 + 32'(8 * i)));
         cyc("t5_dma", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0204 + 32'(8 * i), 32'h0,
             1'b0, 1'b1, 1'b1, 1'b0, 32'h0204 + 32'(8 * i), 32'h0);
      end
      idle("t5_idle");

      // DMA write then LSU read of the written word
      cyc("t7_dwr", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0500, 32'hCAFE_F00D,
          1'b0, 1'b1, 1'b1, 1'b1, 32'h0500, 32'hCAFE_F00D);
      lsu_q.push_back(32'hCAFE_F00D);
      cyc("t7_rd", 1'b1, 32'h0500, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
          1'b0, 1'b0, 1'b1, 1'b0, 32'h0500, 32'h0);
      idle("t7_idle");

      // Reset the cycle after an LSU read grant: the pending return is dropped
      cyc("t6_rd", 1'b1, 32'h0FF0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
          1'b0, 1'b0, 1'b1, 1'b0, 32'h0FF0, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive(1'b1, 32'h0FF0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0);
      #1;
      chk_all_zero("t6_rst");
      @(negedge clk);
      chk_all_zero("t6_rst_neg");
      @(posedge clk); #1;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("t6_no_lsu_rvalid", lsu_dccm_rvalid_out, 1'b0);
         chk1("t6_no_dma_rvalid", dma_rvalid, 1'b0);
      end

      chk32("lsu_q_drained", 32'(lsu_q.size()), 32'h0);
      chk32("dma_q_drained", 32'(dma_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
